fmul_pipe: RTL and testbench
============================

# fmul_pipe

Parametrised, fully pipelined IEEE-754-style multiplier for the FPU. It is the successor to the fixed-format single-precision multiplier. It adds configurable exponent and mantissa widths, selectable round-to-nearest-even, special-value handling, overflow and underflow saturation, exception flags, a tag side-band, and a valid/ready handshake with back-pressure. It sits between the FPU issue stage and the writeback arbiter.

## Interface
- `EXP_W`, 8: exponent field width.
- `MAN_W`, 23: stored mantissa (fraction) width.
- `ROUND_NE`, 1: 1 selects round-to-nearest-even; 0 selects truncation.
- `TAG_W`, 4: width of the opaque tag carried alongside each operation.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block accepts this cycle.
- `op1`, `op2`  in  `EXP_W+MAN_W+1`  operands, {sign, exp, frac}.
- `in_tag`  in  `TAG_W`  tag, returned unchanged with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts this cycle.
- `result`  out  `EXP_W+MAN_W+1`  product.
- `out_tag`  out  `TAG_W`  tag of `result`.
- `flags`  out  3  {invalid, overflow, underflow}.

## Operation
- An operation is accepted on any edge where `in_valid && in_ready`.
- **S1:** unpack operands and classify each as zero, normal, inf or NaN.
  - A subnormal input (exp==0) is treated as a signed zero.
  - Compute the full `(MAN_W+1)x(MAN_W+1)` product with hidden bits. The product is exact; no partial products are dropped.
  - Compute `sign = s1^s2`.
  - Compute the biased exponent `e1+e2-BIAS` at `EXP_W+2` bits, signed.
- **S2:** normalise.
  - If the product MSB is set, shift right by 1 and increment the exponent.
  - Extract the kept `MAN_W` fraction bits, the guard bit, and the sticky bit (OR of all lower bits).
- **S3:** round and pack.
  - RNE: round up when `guard && (sticky || lsb)`. A mantissa carry-out renormalises the result and increments the exponent.
  - Overflow: exp ≥ `2^EXP_W-1` after rounding → signed inf, overflow flag set.
  - Underflow: exp ≤ 0 after rounding → signed zero, underflow flag set. No subnormal outputs are produced.
- **Special values override S3:**
  - Either input NaN → canonical NaN `{0, all-ones, 1, 0...}`, no flags.
  - inf×0 → canonical NaN, invalid flag set.
  - inf×finite-nonzero or inf×inf → signed inf, no flags.
  - zero×finite → signed zero, no flags.

## Timing
- Three register stages. Latency is exactly 3 cycles from acceptance to `out_valid`, with `out_ready` held high.
- Throughput: 1 operation per cycle.
- Global stall: `advance = !out_valid || out_ready`; `in_ready = advance`.
  - `in_ready` is combinational from `out_ready`; the integration layer handles this path.
- When `advance` is low, every stage holds: valid bits, data and tags are frozen.
  - `result`, `out_tag` and `flags` stay stable while `out_valid && !out_ready`.
- Bubbles propagate as cleared per-stage valid bits.
  - A bubble in S3 with `out_ready` low still counts as `!out_valid`, so the pipe advances.
- Reset, asserted asynchronously at any time:
  - All stage valid bits are 0 and `out_valid` is 0.
  - `result`, `out_tag` and `flags` are all 0.
  - In-flight operations are discarded.
- Deassertion is synchronised externally. The first acceptance can occur on the first edge after `rst_n` goes high.
- Simultaneous drain and accept in the same cycle is legal and loses nothing.

## Structure
- Shared package `fpu_pkg` holds:
  - the class enum (zero, normal, inf, nan);
  - the flag bit indices;
  - the `BIAS` function of `EXP_W`;
  - the canonical-NaN constant function.
- Sub-module `fmul_round`: combinational S3 logic. Inputs: sign, exponent, fraction, guard, sticky, class. Outputs: packed result and flags. It is instantiated once and reused by the future fused-multiply-add.

## Test plan
- Basic timing: `0x3FC00000 × 0x40000000`, tag 5 → `0x40400000`, flags 000, `out_tag`=5, `out_valid` exactly 3 cycles after acceptance.
- Tie rounding: `0x3F800001 × 0x3FC00000` → `0x3FC00002` with `ROUND_NE=1`; `0x3FC00001` with `ROUND_NE=0`.
- Overflow: `0x7F000000 × 0x40000000` → `0x7F800000`, overflow flag. `0xFF000000 × 0x40000000` → `0xFF800000`, overflow flag.
- Underflow and inf×0:
  - `0x00800000 × 0xBF000000` → `0x80000000`, underflow flag.
  - `0x7F800000 × 0x00000000` → `0x7FC00000`, invalid flag.
  - `0x7FC00001 × 0x3F800000` → `0x7FC00000`, no flags.
- Back-pressure: 8 back-to-back operations with tags 0–7, `out_ready` low during cycles 3–6.
  - `in_ready` follows `out_ready`.
  - Results arrive in order, none lost or duplicated.
  - `result` stays stable while stalled.
- Reset mid-stream: `rst_n` pulsed low with 3 operations in flight.
  - `out_valid` drops immediately, with no clock edge required.
  - No stale result is emitted after release.
  - The next operation completes with 3-cycle latency.

Source files
------------

// File: rtl/fpu_pkg.sv
// Definitions shared by the FPU datapath blocks: operand classes, flag bit
// positions, exponent bias and the canonical quiet NaN.
package fpu_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fclass_e;

    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned in the low exp_w+man_w+1 bits: {0, all-ones exponent, 1, zeros}.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational round-and-pack stage: rounds a normalised significand, applies
// overflow/underflow saturation and resolves special operand classes.
module fmul_round
    import fpu_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int ROUND_NE = 1
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   exp_in,
    input  logic [MAN_W-1:0]          frac,
    input  logic                      guard,
    input  logic                      sticky,
    input  fclass_e                   cls1,
    input  fclass_e                   cls2,
    output logic [EXP_W+MAN_W:0]      result,
    output logic [2:0]                flags
);

    localparam int W = EXP_W + MAN_W + 1;
    localparam logic [63:0] NAN64 = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0] NAN_W = NAN64[W-1:0];
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

    logic                    round_up;
    logic [MAN_W:0]          mant_r;
    logic signed [EXP_W+1:0] exp_r;

    always_comb begin
        round_up = (ROUND_NE != 0) && guard && (sticky || frac[0]);
        mant_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        // A carry-out leaves the kept fraction at zero, so only the exponent moves.
        exp_r    = mant_r[MAN_W] ? exp_in + (EXP_W+2)'(1) : exp_in;

        result = {sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        flags  = 3'b000;

        if (cls1 == CLS_NAN || cls2 == CLS_NAN) begin
            result = NAN_W;
        end else if ((cls1 == CLS_INF && cls2 == CLS_ZERO) ||
                     (cls2 == CLS_INF && cls1 == CLS_ZERO)) begin
            result              = NAN_W;
            flags[FLAG_INVALID] = 1'b1;
        end else if (cls1 == CLS_INF || cls2 == CLS_INF) begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls1 == CLS_ZERO || cls2 == CLS_ZERO) begin
            result = {sign, {(W-1){1'b0}}};
        end else if (!exp_r[EXP_W+1] && exp_r >= EXP_MAX) begin
            result               = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_r[EXP_W+1] || exp_r == '0) begin
            result                = {sign, {(W-1){1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// S1 unpacks and multiplies, S2 normalises, S3 registers the rounded result.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int ROUND_NE = 1,
    parameter int TAG_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op1,
    input  logic [EXP_W+MAN_W:0]     op2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [2:0]               flags
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias(EXP_W));

    function automatic fclass_e classify(input logic [W-1:0] op);
        if (op[W-2:MAN_W] == '0) return CLS_ZERO;
        if (op[W-2:MAN_W] == '1) return (op[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORMAL;
    endfunction

    logic advance;

    logic                    s1_valid, s1_sign;
    logic signed [EXP_W+1:0] s1_exp;
    logic [PW-1:0]           s1_prod;
    fclass_e                 s1_cls1, s1_cls2;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s2_valid, s2_sign, s2_guard, s2_sticky;
    logic signed [EXP_W+1:0] s2_exp;
    logic [MAN_W-1:0]        s2_frac;
    fclass_e                 s2_cls1, s2_cls2;
    logic [TAG_W-1:0]        s2_tag;

    logic [PW-1:0]           prod_n, norm_n;
    logic signed [EXP_W+1:0] exp1_n, exp2_n;
    logic [W-1:0]            rnd_result;
    logic [2:0]              rnd_flags;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        prod_n = {1'b1, op1[MAN_W-1:0]} * {1'b1, op2[MAN_W-1:0]};
        exp1_n = $signed({2'b00, op1[W-2:MAN_W]}) + $signed({2'b00, op2[W-2:MAN_W]}) - BIAS_S;
        // Product lies in [1,4); align its leading one to the top bit.
        norm_n = s1_prod[PW-1] ? s1_prod : (s1_prod << 1);
        exp2_n = s1_prod[PW-1] ? s1_exp + (EXP_W+2)'(1) : s1_exp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_prod   <= '0;
            s1_cls1   <= CLS_ZERO;
            s1_cls2   <= CLS_ZERO;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_frac   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_cls1   <= CLS_ZERO;
            s2_cls2   <= CLS_ZERO;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sign   <= op1[W-1] ^ op2[W-1];
            s1_exp    <= exp1_n;
            s1_prod   <= prod_n;
            s1_cls1   <= classify(op1);
            s1_cls2   <= classify(op2);
            s1_tag    <= in_tag;

            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_exp    <= exp2_n;
            s2_frac   <= norm_n[PW-2 -: MAN_W];
            s2_guard  <= norm_n[PW-2-MAN_W];
            s2_sticky <= |norm_n[PW-3-MAN_W:0];
            s2_cls1   <= s1_cls1;
            s2_cls2   <= s1_cls2;
            s2_tag    <= s1_tag;

            out_valid <= s2_valid;
            result    <= rnd_result;
            out_tag   <= s2_tag;
            flags     <= rnd_flags;
        end
    end

    fmul_round #(
        .EXP_W    (EXP_W),
        .MAN_W    (MAN_W),
        .ROUND_NE (ROUND_NE)
    ) u_round (
        .sign   (s2_sign),
        .exp_in (s2_exp),
        .frac   (s2_frac),
        .guard  (s2_guard),
        .sticky (s2_sticky),
        .cls1   (s2_cls1),
        .cls2   (s2_cls2),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: a round-to-nearest and a truncating instance
// share stimulus and are both checked against an arithmetic reference model.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready_t;
    logic [31:0] op1 = '0, op2 = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid, out_valid_t;
    logic        out_ready = 1'b1;
    logic [31:0] result, result_t;
    logic [3:0]  out_tag, out_tag_t;
    logic [2:0]  flags, flags_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    typedef struct {
        logic [31:0] r_ne;
        logic [2:0]  f_ne;
        logic [31:0] r_tr;
        logic [2:0]  f_tr;
        logic [3:0]  tag;
    } exp_t;
    exp_t q[$];

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_NE(1), .TAG_W(4)) u_rne (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_tag(out_tag), .flags(flags)
    );

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_NE(0), .TAG_W(4)) u_trn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .op1(op1), .op2(op2), .in_tag(in_tag), .out_valid(out_valid_t),
        .out_ready(out_ready), .result(result_t), .out_tag(out_tag_t), .flags(flags_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Reference: exact integer product, rounded by comparing the discarded
    // remainder against one half ulp. Returns {flags, result}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input bit rne);
        logic   s;
        int     ea, eb, e, sh;
        longint p, m, rem, half;
        bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {3'b000, 32'h7FC00000};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {3'b100, 32'h7FC00000};
        if (a_inf || b_inf) return {3'b000, s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {3'b000, s, 31'd0};
        p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'sd1 <<< 47)) begin
            sh = 24;
            e++;
        end
        m    = p >>> sh;
        rem  = p - (m <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rne && ((rem > half) || (rem == half && m[0]))) m++;
        if (m == (64'sd1 <<< 24)) begin
            m = m >>> 1;
            e++;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {3'b001, s, 31'd0};
        return {3'b000, s, e[7:0], m[22:0]};
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        exp_t x;
        logic [34:0] v;
        v      = model(a, b, 1'b1);
        x.r_ne = v[31:0];
        x.f_ne = v[34:32];
        v      = model(a, b, 1'b0);
        x.r_tr = v[31:0];
        x.f_tr = v[34:32];
        x.tag  = t;
        return x;
    endfunction

    // Compare process: every cycle, away from the active edge.
    logic        stalled_prev = 1'b0;
    logic [31:0] held_result;
    logic [3:0]  held_tag;
    logic [2:0]  held_flags;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            check("trn_valid_align", 64'(out_valid_t), 64'(out_valid));
            if (stalled_prev) begin
                check("stall_result", 64'(result), 64'(held_result));
                check("stall_tag", 64'(out_tag), 64'(held_tag));
                check("stall_flags", 64'(flags), 64'(held_flags));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail_now("spurious_output");
                end else begin
                    e = q[0];
                    check("result", 64'(result), 64'(e.r_ne));
                    check("flags", 64'(flags), 64'(e.f_ne));
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                    check("trn_result", 64'(result_t), 64'(e.r_tr));
                    check("trn_flags", 64'(flags_t), 64'(e.f_tr));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(mk(op1, op2, in_tag));
            stalled_prev = out_valid && !out_ready;
            held_result  = result;
            held_tag     = out_tag;
            held_flags   = flags;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        op1      = a;
        op2      = b;
        in_tag   = t;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) fail_now("send_timeout");
        in_valid = 1'b0;
    endtask

    // Issue one op on an idle pipe and measure edges from acceptance to out_valid.
    task automatic run_latency(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                               input logic [31:0] exp_r, input string name);
        int lat;
        bit seen;
        send(a, b, t);
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) fail_now({name, "_timeout"});
        else begin
            check({name, "_latency"}, 64'(lat), 64'd3);
            check({name, "_result"}, 64'(result), 64'(exp_r));
            check({name, "_tag"}, 64'(out_tag), 64'(t));
            check({name, "_flags"}, 64'(flags), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] va[16];
    logic [31:0] vb[16];

    initial begin
        int out_before;

        check("pin_basic",   64'(model(32'h3FC00000, 32'h40000000, 1'b1)), 64'({3'b000, 32'h40400000}));
        check("pin_tie_rne", 64'(model(32'h3F800001, 32'h3FC00000, 1'b1)), 64'({3'b000, 32'h3FC00002}));
        check("pin_tie_trn", 64'(model(32'h3F800001, 32'h3FC00000, 1'b0)), 64'({3'b000, 32'h3FC00001}));
        check("pin_ovf_pos", 64'(model(32'h7F000000, 32'h40000000, 1'b1)), 64'({3'b010, 32'h7F800000}));
        check("pin_ovf_neg", 64'(model(32'hFF000000, 32'h40000000, 1'b1)), 64'({3'b010, 32'hFF800000}));
        check("pin_udf",     64'(model(32'h00800000, 32'hBF000000, 1'b1)), 64'({3'b001, 32'h80000000}));
        check("pin_inf_x0",  64'(model(32'h7F800000, 32'h00000000, 1'b1)), 64'({3'b100, 32'h7FC00000}));
        check("pin_nan",     64'(model(32'h7FC00001, 32'h3F800000, 1'b1)), 64'({3'b000, 32'h7FC00000}));
        check("pin_neg",     64'(model(32'hC0000000, 32'h40400000, 1'b1)), 64'({3'b000, 32'hC0C00000}));

        // Reset state
        idle(2);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_latency(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, "basic");

        va = '{32'h3F800001, 32'h7F000000, 32'hFF000000, 32'h00800000,
               32'h7F800000, 32'h7FC00001, 32'hC0000000, 32'h00000000,
               32'h80000000, 32'h7F800000, 32'h007FFFFF, 32'h3F800000,
               32'h3FFFFFFF, 32'h3FBFFFFF, 32'h40490FDB, 32'h1F800000};
        vb = '{32'h3FC00000, 32'h40000000, 32'h40000000, 32'hBF000000,
               32'h00000000, 32'h3F800000, 32'h40400000, 32'h40000000,
               32'h3F800000, 32'hFF800000, 32'h7F800000, 32'h3F800000,
               32'h3FFFFFFF, 32'h40000001, 32'hC02DF854, 32'h1F800000};
        for (int i = 0; i < 16; i++) send(va[i], vb[i], 4'(i));
        idle(6);
        check("directed_drained", 64'(q.size()), 64'd0);

        // Back-pressure: 8 back-to-back ops, out_ready low in cycles 3..6
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(va[i+6], vb[i+6], 4'(i));
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        check("bp_count", 64'(n_out - out_before), 64'd8);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Reset with three operations in flight
        send(32'h40000000, 32'h40000000, 4'd1);
        send(32'h40400000, 32'h40000000, 4'd2);
        send(32'h40800000, 32'h40000000, 4'd3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_async", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        q.delete();
        idle(2);
        #2 rst_n = 1'b1;
        idle(6);
        check("post_rst_idle", 64'(out_valid), 64'd0);
        run_latency(32'h40000000, 32'h40400000, 4'd9, 32'h40C00000, "post_rst");
        idle(4);
        check("final_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
